ped_crossing_ctrl: RTL
======================

// Module: ped_crossing_ctrl
// PURPOSE
//  Parametrised pedestrian-crossing controller, next generation of the fixed-timing crossing FSM.
//  Adds: on-demand pedestrian phase (N request buttons, latched, WAIT lamp), minimum car green,
//  tick prescaler so phase times are set in ticks, and a maintenance mode with flashing amber.
//  Drives the road and pedestrian lamp outputs directly; sits between button/switch sync and lamp drivers.
// PARAMETERS
//  TICK_DIV     50_000_000  clk cycles per tick (1 s at 50 MHz); >=1
//  N_BUTTONS    2           number of pedestrian request inputs; >=1
//  T_GREEN_MIN  5           minimum car green, ticks; >=1
//  T_YELLOW     1           car amber, ticks; >=1
//  T_ALL_RED    1           all-red clearance (both directions), ticks; >=1
//  T_PED_GREEN  4           steady pedestrian green, ticks; >=1
//  T_PED_BLINK  2           blinking pedestrian green, ticks; >=1
//  T_RED_YELLOW 1           car red+amber, ticks; >=1
//  BLINK_HALF   1           blink half-period, ticks (PED blink and MAINT amber); >=1
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous, active-high reset
//  ped_req      in   N_BUTTONS  pedestrian request, level; any bit high = request (already synchronised)
//  maint        in   1          maintenance mode request, level
//  ROAD_RED     out  1          road red lamp
//  ROAD_YELLOW  out  1          road amber lamp
//  ROAD_GREEN   out  1          road green lamp
//  PED_RED      out  1          pedestrian red lamp
//  PED_GREEN    out  1          pedestrian green lamp
//  PED_WAIT     out  1          "request registered" lamp = req_pending
//  state_o      out  3          current state encoding (debug/verification)
// BEHAVIOUR
//  - Reset (async): state=CAR_GREEN, prescaler=0, phase counter=T_GREEN_MIN-1, req_pending=0, blink=1.
//    Outputs at reset: ROAD_GREEN=1, PED_RED=1, all others 0, state_o=0.
//  - Lamps are a Moore decode of registered state/blink only; no input reaches outputs combinationally.
//  - Prescaler restarts at 0 on every state entry; tick = prescaler==TICK_DIV-1. Phase counter loads T_x-1
//    on entry, decrements on tick, saturates at 0. Timed phase ends on the tick with counter==0, so
//    each timed state lasts exactly T_x*TICK_DIV cycles.
//  - States / lamps / exit:
//    CAR_GREEN(0)  RG,PR   counter==0 & tick & (req_pending|maint) -> CAR_YELLOW; else hold
//    CAR_YELLOW(1) RY,PR   end -> MAINT if maint else ALL_RED_1
//    ALL_RED_1(2)  RR,PR   end -> PED_GREEN
//    PED_GREEN(3)  RR,PG   end -> PED_BLINK
//    PED_BLINK(4)  RR,PG=blink  end -> ALL_RED_2
//    ALL_RED_2(5)  RR,PR   end -> CAR_RED_YELLOW
//    CAR_RED_YEL(6) RR,RY,PR  end -> CAR_GREEN (counter T_GREEN_MIN-1)
//    MAINT(7)      RY=blink, all others 0   tick & !maint -> ALL_RED_2
//  - req_pending: set when |ped_req in any state except PED_GREEN, PED_BLINK, MAINT; cleared on entry to
//    PED_GREEN and to MAINT. Set and clear in same cycle: clear wins.
//  - maint honoured only from CAR_GREEN (after min green) and at CAR_YELLOW end; other states finish the
//    normal sequence first. maint has priority over req_pending at CAR_YELLOW end.
//  - blink: set to 1 on entry to PED_BLINK/MAINT; toggles every BLINK_HALF ticks within those states.
//  - Invariant: PED_GREEN=1 only when ROAD_RED=1 and ROAD_GREEN=ROAD_YELLOW=0.
//  - Illegal state encoding: recover to CAR_GREEN next cycle.
// STRUCTURE
//  - ped_xing_pkg: state_t enum (3-bit, encodings above), lamp_t struct, state->lamp decode function.
//  - Sub-module tick_prescaler (TICK_DIV; clk, rst, restart, tick). Counter widths via $clog2 of max T_x.
// TESTING  (TICK_DIV=4, T_GREEN_MIN=3, T_YELLOW=1, T_ALL_RED=1, T_PED_GREEN=4, T_PED_BLINK=2,
//           T_RED_YELLOW=1, BLINK_HALF=1)
//  1. No ped_req/maint for 500 cycles -> CAR_GREEN throughout, PED_WAIT=0.
//  2. 1-cycle ped_req[1] at cycle 2 after reset -> PED_WAIT=1 from cycle 3; YELLOW at 12, ALL_RED_1 16,
//     PED_GREEN 20 (PED_WAIT=0), PED_BLINK 36 with PED_GREEN 1,0 per 4 cycles, ALL_RED_2 44, RED_YEL 48, GREEN 52.
//  3. ped_req during PED_GREEN -> ignored; ped_req during CAR_RED_YEL -> latched, next YELLOW 12 cycles after GREEN entry.
//  4. maint=1 during PED_GREEN -> sequence completes to CAR_GREEN, min green, YELLOW, MAINT with ROAD_YELLOW
//     toggling every 4 cycles, PED lamps 0; maint=0 -> ALL_RED_2, CAR_RED_YEL, CAR_GREEN.
//  5. rst pulse mid PED_BLINK (async, between edges) -> reset outputs immediately, req_pending=0, restart as test 1.
//  6. Randomised ped_req/maint 20k cycles with invariant assertion and per-state duration checks.

Source files
------------

// File: rtl/ped_xing_pkg.sv
// Shared types and helpers for the pedestrian-crossing controller.
package ped_xing_pkg;

    typedef enum logic [2:0] {
        S_CAR_GREEN   = 3'd0,
        S_CAR_YELLOW  = 3'd1,
        S_ALL_RED_1   = 3'd2,
        S_PED_GREEN   = 3'd3,
        S_PED_BLINK   = 3'd4,
        S_ALL_RED_2   = 3'd5,
        S_CAR_RED_YEL = 3'd6,
        S_MAINT       = 3'd7
    } state_t;

    typedef struct packed {
        logic road_red;
        logic road_yellow;
        logic road_green;
        logic ped_red;
        logic ped_green;
    } lamp_t;

    // Moore lamp pattern for a state; blink gates the flashing lamps.
    function automatic lamp_t lamp_decode(state_t s, logic blink);
        lamp_t l;
        l = '0;
        case (s)
            S_CAR_GREEN:   begin l.road_green = 1'b1; l.ped_red = 1'b1; end
            S_CAR_YELLOW:  begin l.road_yellow = 1'b1; l.ped_red = 1'b1; end
            S_ALL_RED_1:   begin l.road_red = 1'b1; l.ped_red = 1'b1; end
            S_PED_GREEN:   begin l.road_red = 1'b1; l.ped_green = 1'b1; end
            S_PED_BLINK:   begin l.road_red = 1'b1; l.ped_green = blink; end
            S_ALL_RED_2:   begin l.road_red = 1'b1; l.ped_red = 1'b1; end
            S_CAR_RED_YEL: begin l.road_red = 1'b1; l.road_yellow = 1'b1; l.ped_red = 1'b1; end
            S_MAINT:       begin l.road_yellow = blink; end
            default:       begin l.road_red = 1'b1; l.ped_red = 1'b1; end
        endcase
        return l;
    endfunction

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV cycles; restart realigns the phase.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider, cleared on restart or wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: on-demand ped phase, minimum car green, maintenance flash.
module ped_crossing_ctrl
    import ped_xing_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned N_BUTTONS    = 2,
    parameter int unsigned T_GREEN_MIN  = 5,
    parameter int unsigned T_YELLOW     = 1,
    parameter int unsigned T_ALL_RED    = 1,
    parameter int unsigned T_PED_GREEN  = 4,
    parameter int unsigned T_PED_BLINK  = 2,
    parameter int unsigned T_RED_YELLOW = 1,
    parameter int unsigned BLINK_HALF   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] ped_req,
    input  logic                 maint,
    output logic                 ROAD_RED,
    output logic                 ROAD_YELLOW,
    output logic                 ROAD_GREEN,
    output logic                 PED_RED,
    output logic                 PED_GREEN,
    output logic                 PED_WAIT,
    output logic [2:0]           state_o
);
    localparam int unsigned T_MAX = max_u(max_u(max_u(T_GREEN_MIN, T_YELLOW), max_u(T_ALL_RED, T_PED_GREEN)),
                                          max_u(max_u(T_PED_BLINK, T_RED_YELLOW), BLINK_HALF));
    localparam int unsigned PW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t        state, state_next;
    logic [PW-1:0] phase_cnt, phase_next;
    logic [PW-1:0] blink_cnt, blink_cnt_next;
    logic          blink, blink_next;
    logic          req_pending, req_next;
    logic          tick, entry, phase_end;
    lamp_t         lamps;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .restart (entry),
        .tick    (tick)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_CAR_GREEN;
            phase_cnt   <= PW'(T_GREEN_MIN - 1);
            blink_cnt   <= PW'(BLINK_HALF - 1);
            blink       <= 1'b1;
            req_pending <= 1'b0;
        end else begin
            state       <= state_next;
            phase_cnt   <= phase_next;
            blink_cnt   <= blink_cnt_next;
            blink       <= blink_next;
            req_pending <= req_next;
        end
    end

    // Next state, phase counter, blink and request latch.
    always_comb begin
        state_next     = state;
        phase_next     = phase_cnt;
        blink_cnt_next = blink_cnt;
        blink_next     = blink;
        req_next       = req_pending;
        phase_end      = tick && (phase_cnt == '0);

        case (state)
            S_CAR_GREEN:   if (phase_end && (req_pending || maint)) state_next = S_CAR_YELLOW;
            S_CAR_YELLOW:  if (phase_end) state_next = maint ? S_MAINT : S_ALL_RED_1;
            S_ALL_RED_1:   if (phase_end) state_next = S_PED_GREEN;
            S_PED_GREEN:   if (phase_end) state_next = S_PED_BLINK;
            S_PED_BLINK:   if (phase_end) state_next = S_ALL_RED_2;
            S_ALL_RED_2:   if (phase_end) state_next = S_CAR_RED_YEL;
            S_CAR_RED_YEL: if (phase_end) state_next = S_CAR_GREEN;
            S_MAINT:       if (tick && !maint) state_next = S_ALL_RED_2;
            default:       state_next = S_CAR_GREEN;
        endcase

        entry = (state_next != state);

        // Phase length loads on entry, otherwise counts ticks down to zero.
        if (entry) begin
            case (state_next)
                S_CAR_GREEN:   phase_next = PW'(T_GREEN_MIN - 1);
                S_CAR_YELLOW:  phase_next = PW'(T_YELLOW - 1);
                S_ALL_RED_1:   phase_next = PW'(T_ALL_RED - 1);
                S_PED_GREEN:   phase_next = PW'(T_PED_GREEN - 1);
                S_PED_BLINK:   phase_next = PW'(T_PED_BLINK - 1);
                S_ALL_RED_2:   phase_next = PW'(T_ALL_RED - 1);
                S_CAR_RED_YEL: phase_next = PW'(T_RED_YELLOW - 1);
                default:       phase_next = '0;
            endcase
        end else if (tick && (phase_cnt != '0)) begin
            phase_next = phase_cnt - PW'(1);
        end

        // Blink restarts lit on entry to a flashing state.
        if (entry && ((state_next == S_PED_BLINK) || (state_next == S_MAINT))) begin
            blink_next     = 1'b1;
            blink_cnt_next = PW'(BLINK_HALF - 1);
        end else if (tick && ((state == S_PED_BLINK) || (state == S_MAINT))) begin
            if (blink_cnt == '0) begin
                blink_next     = ~blink;
                blink_cnt_next = PW'(BLINK_HALF - 1);
            end else begin
                blink_cnt_next = blink_cnt - PW'(1);
            end
        end

        // Requests latch outside the ped/maint phases; serving the phase clears them.
        if ((|ped_req) && !(state inside {S_PED_GREEN, S_PED_BLINK, S_MAINT})) begin
            req_next = 1'b1;
        end
        if (entry && ((state_next == S_PED_GREEN) || (state_next == S_MAINT))) begin
            req_next = 1'b0;
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        lamps       = lamp_decode(state, blink);
        ROAD_RED    = lamps.road_red;
        ROAD_YELLOW = lamps.road_yellow;
        ROAD_GREEN  = lamps.road_green;
        PED_RED     = lamps.ped_red;
        PED_GREEN   = lamps.ped_green;
        PED_WAIT    = req_pending;
        state_o     = 3'(state);
    end

endmodule
